cpu_trace_monitor: RTL and testbench
====================================

// Module: cpu_trace_monitor
// PURPOSE
//  Synthesizable, parametrised execution monitor attached to the CPU core's retire, register-bank and
//  data-memory write ports. Captures PC/SP, register writes and memory writes into a trace FIFO that
//  a host or bench drains via valid/ready. Detects self-loop halts and retire timeouts, then requests
//  a CPU halt, replacing free-running $monitor dumps in simulation and on silicon.
// PARAMETERS
//  DATA_W        32       register / memory data width
//  ADDR_W        32       PC, SP and memory address width
//  NREG          8        register-bank entries; reg index width RW = $clog2(NREG)
//  TRACE_DEPTH   16       trace FIFO entries, power of two, >= 2
//  TIMEOUT       1000000  cycles without a retire before timeout is flagged
//  STALL_RETIRES 4        consecutive retires at an unchanged PC that count as a halt loop
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              synchronous, active-high reset
//  trace_en     in   1              1 = capture events into the FIFO
//  clear        in   1              return FSM to RUN, zero the watchdog and stall counters
//  retire       in   1              one instruction retired this cycle
//  pc           in   ADDR_W         PC of the retiring instruction
//  sp           in   ADDR_W         stack pointer at retire
//  reg_we       in   1              register-bank write strobe
//  reg_waddr    in   RW             register index written
//  reg_wdata    in   DATA_W         register write data
//  mem_we       in   1              data-memory write strobe
//  mem_waddr    in   ADDR_W         memory write address
//  mem_wdata    in   DATA_W         memory write data
//  trace_valid  out  1              FIFO non-empty
//  trace_ready  in   1              consumer pops the head entry when trace_valid=1
//  trace_data   out  2+ADDR_W+DATA_W head entry {type[1:0], addr, data}, show-ahead
//  trace_count  out  $clog2(TRACE_DEPTH)+1  current FIFO occupancy
//  drop_count   out  16             events lost, saturating at 16'hFFFF
//  halt_req     out  1              registered request to the CPU to halt
//  status       out  2              00 RUN, 01 HALTED (self-loop), 10 TIMEOUT
// BEHAVIOUR
//  Reset: FIFO empty, trace_valid=0, trace_data=0, trace_count=0, drop_count=0, halt_req=0,
//   status=RUN, all internal counters 0. Reset mid-operation flushes the FIFO with no pop handshake.
//  Entry types: 00 retire {addr=pc, data=sp zero-extended or truncated to DATA_W}; 01 reg write
//   {addr=reg_waddr zero-extended, data=reg_wdata}; 10 mem write {addr=mem_waddr, data=mem_wdata}.
//  One push per cycle. Priority: mem write > reg write > retire. Each lower-priority event in the
//   same cycle increments drop_count by 1, so a three-event cycle adds 2.
//  Push occurs when trace_en=1 and status==RUN. A push to a full FIFO is dropped and counted,
//   unless a pop happens the same cycle, in which case both the push and the pop occur.
//  A push into an empty FIFO makes trace_valid=1 in the next cycle (1-cycle latency).
//  Pop: trace_valid & trace_ready. trace_ready is ignored when the FIFO is empty. Pointers wrap
//   modulo TRACE_DEPTH.
//  FSM RUN:
//   - Watchdog: wd_cnt resets to 0 on retire, otherwise increments. When wd_cnt reaches
//     TIMEOUT-1 with no retire, the FSM moves to TIMEOUT on the next edge.
//   - Stall: on each retire, if pc == last_pc then stall_cnt+1, else stall_cnt=1; last_pc <= pc.
//     When stall_cnt reaches STALL_RETIRES, the FSM moves to HALTED.
//   - If both conditions hit in the same cycle, HALTED wins.
//  FSM HALTED or TIMEOUT: halt_req=1 and capture is frozen. The FIFO remains drainable.
//   Watchdog and stall counters hold their values.
//  clear (any state) -> RUN on the next edge: halt_req=0, wd_cnt=0, stall_cnt=0, last_pc kept.
//   FIFO contents and drop_count are preserved. rst takes precedence over clear.
//  halt_req and status are registered and change on the edge after the triggering condition.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> trace_valid=0, trace_count=0, drop_count=0, halt_req=0, status=00.
//  T2 capture order: retire pc=0x10 sp=0x3FC, then reg_we r3=0x55, then mem_we [0x4]=0x99 on
//   separate cycles -> three pops return type 00/0x10/0x3FC, 01/3/0x55, 10/0x4/0x99.
//  T3 collision and overflow: mem_we, reg_we and retire in one cycle -> only the mem entry is
//   queued, drop_count=2. Fill 16 entries with trace_ready=0, push 17th -> drop_count+1,
//   trace_count=16. Push and pop in the same full cycle -> trace_count stays 16, no drop.
//  T4 self-loop: 4 retires at pc=0x20 -> status=01 and halt_req=1 one edge after the 4th retire;
//   further events are not queued. clear -> status=00.
//  T5 timeout (TIMEOUT=8 override): retire, then 8 idle cycles -> status=10, halt_req=1.
//   A retire at idle cycle 7 prevents the timeout.
//  T6 reset mid-run: FIFO holding 5 entries and status=10, assert rst -> all reset values next edge.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// Execution trace monitor: captures retire / reg-write / mem-write events
// into a show-ahead FIFO and raises a halt request on self-loop or timeout.
module cpu_trace_monitor #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int NREG          = 8,
  parameter int TRACE_DEPTH   = 16,
  parameter int TIMEOUT       = 1000000,
  parameter int STALL_RETIRES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trace_en,
  input  logic                          clear,
  input  logic                          retire,
  input  logic [ADDR_W-1:0]             pc,
  input  logic [ADDR_W-1:0]             sp,
  input  logic                          reg_we,
  input  logic [$clog2(NREG)-1:0]       reg_waddr,
  input  logic [DATA_W-1:0]             reg_wdata,
  input  logic                          mem_we,
  input  logic [ADDR_W-1:0]             mem_waddr,
  input  logic [DATA_W-1:0]             mem_wdata,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [2+ADDR_W+DATA_W-1:0]    trace_data,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic [15:0]                   drop_count,
  output logic                          halt_req,
  output logic [1:0]                    status
);

  localparam int PW  = $clog2(TRACE_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = 2 + ADDR_W + DATA_W;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int SCW = $clog2(STALL_RETIRES + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TMO  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              halt_q, halt_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic [SCW-1:0]    stall_q, stall_d, stall_inc;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       drop_q, drop_d;
  logic [16:0]       drop_sum;
  logic [EW-1:0]     mem_q [TRACE_DEPTH];

  logic          capture, push, pop, full;
  logic          stall_hit, wd_hit;
  logic [1:0]    n_ev, n_drop;
  logic [EW-1:0] entry;

  // Event selection: highest-priority event wins, the rest are drops
  always_comb begin
    n_ev  = 2'(mem_we) + 2'(reg_we) + 2'(retire);
    entry = '0;
    if (mem_we)
      entry = {2'b10, mem_waddr, mem_wdata};
    else if (reg_we)
      entry = {2'b01, ADDR_W'(reg_waddr), reg_wdata};
    else if (retire)
      entry = {2'b00, pc, DATA_W'(sp)};
    full   = (count_q == CW'(TRACE_DEPTH));
    pop    = (count_q != '0) && trace_ready;
    push   = capture && (n_ev != 2'd0) && (!full || pop);
    n_drop = 2'd0;
    if (capture && n_ev != 2'd0)
      n_drop = push ? n_ev - 2'd1 : n_ev;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    stall_inc = (pc == last_pc_q) ? stall_q + SCW'(1) : SCW'(1);
    stall_hit = (state_q == ST_RUN) && retire &&
                (stall_inc == SCW'(STALL_RETIRES));
    wd_hit    = (state_q == ST_RUN) && !retire &&
                (wd_q == WDW'(TIMEOUT - 1));
    wd_d      = wd_q;
    stall_d   = stall_q;
    last_pc_d = last_pc_q;
    if (clear) begin
      wd_d    = '0;
      stall_d = '0;
    end else if (state_q == ST_RUN) begin
      wd_d = retire ? '0 : wd_q + WDW'(1);
      if (retire) begin
        stall_d   = stall_inc;
        last_pc_d = pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = ST_RUN;
    else begin
      case (state_q)
        ST_RUN: begin
          if (stall_hit)   state_d = ST_HALT;
          else if (wd_hit) state_d = ST_TMO;
        end
        default: state_d = state_q;
      endcase
    end
    halt_d = (state_d != ST_RUN);
  end

  always_comb begin
    capture     = trace_en && (state_q == ST_RUN);
    status      = state_q;
    halt_req    = halt_q;
    trace_valid = (count_q != '0);
    trace_count = count_q;
    drop_count  = drop_q;
    trace_data  = trace_valid ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      halt_q    <= 1'b0;
      wd_q      <= '0;
      stall_q   <= '0;
      last_pc_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      wd_q      <= wd_d;
      stall_q   <= stall_d;
      last_pc_q <= last_pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= entry;
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: default instance plus a
// short-timeout instance sharing the same stimulus.
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        rst, trace_en, clear, retire;
  logic [31:0] pc, sp;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_wdata;
  logic        trace_ready;

  logic        tv, htq;
  logic [65:0] td;
  logic [4:0]  tc;
  logic [15:0] dc;
  logic [1:0]  st;

  logic        tv_t, htq_t;
  logic [65:0] td_t;
  logic [4:0]  tc_t;
  logic [15:0] dc_t;
  logic [1:0]  st_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_trace_monitor dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .clear(clear),
    .retire(retire), .pc(pc), .sp(sp),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .trace_valid(tv), .trace_ready(trace_ready), .trace_data(td),
    .trace_count(tc), .drop_count(dc), .halt_req(htq), .status(st)
  );

  cpu_trace_monitor #(.TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst), .trace_en(trace_en), .clear(clear),
    .retire(retire), .pc(pc), .sp(sp),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .trace_valid(tv_t), .trace_ready(trace_ready), .trace_data(td_t),
    .trace_count(tc_t), .drop_count(dc_t), .halt_req(htq_t), .status(st_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; trace_en = 1'b1; clear = 1'b0; retire = 1'b0;
    pc = '0; sp = '0; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; trace_ready = 1'b0;

    // T1 reset
    ticks(2);
    chk("t1_valid", tv, 0);
    chk("t1_count", tc, 0);
    chk("t1_drop", dc, 0);
    chk("t1_halt", htq, 0);
    chk("t1_status", st, 0);
    chk("t1_data", td, 0);
    chk("t1_status_t", st_t, 0);
    rst = 1'b0;

    // T2 capture order
    retire = 1'b1; pc = 32'h10; sp = 32'h3FC;
    tick();
    retire = 1'b0;
    chk("t2_valid1", tv, 1);
    reg_we = 1'b1; reg_waddr = 3'd3; reg_wdata = 32'h55;
    tick();
    reg_we = 1'b0;
    mem_we = 1'b1; mem_waddr = 32'h4; mem_wdata = 32'h99;
    tick();
    mem_we = 1'b0;
    chk("t2_count3", tc, 3);
    chk("t2_pop0", td, {2'b00, 32'h10, 32'h3FC});
    trace_ready = 1'b1;
    tick();
    chk("t2_pop1", td, {2'b01, 32'h3, 32'h55});
    tick();
    chk("t2_pop2", td, {2'b10, 32'h4, 32'h99});
    tick();
    trace_ready = 1'b0;
    chk("t2_empty_valid", tv, 0);
    chk("t2_empty_count", tc, 0);

    // T3 collision and overflow
    mem_we = 1'b1; mem_waddr = 32'h8; mem_wdata = 32'hA1;
    reg_we = 1'b1; reg_waddr = 3'd5; reg_wdata = 32'h77;
    retire = 1'b1; pc = 32'h30; sp = 32'h100;
    tick();
    mem_we = 1'b0; retire = 1'b0;
    chk("t3_coll_count", tc, 1);
    chk("t3_coll_drop", dc, 2);
    chk("t3_coll_data", td, {2'b10, 32'h8, 32'hA1});
    for (int i = 0; i < 15; i++) begin
      reg_waddr = 3'(i); reg_wdata = 32'(i);
      tick();
    end
    chk("t3_full_count", tc, 16);
    chk("t3_full_drop", dc, 2);
    reg_waddr = 3'd6; reg_wdata = 32'hEE;
    tick();
    chk("t3_ovf_count", tc, 16);
    chk("t3_ovf_drop", dc, 3);
    reg_waddr = 3'd7; reg_wdata = 32'hF0; trace_ready = 1'b1;
    tick();
    reg_we = 1'b0; trace_ready = 1'b0;
    chk("t3_pp_count", tc, 16);
    chk("t3_pp_drop", dc, 3);
    chk("t3_pp_head", td, {2'b01, 32'h0, 32'h0});
    trace_ready = 1'b1;
    ticks(15);
    trace_ready = 1'b0;
    chk("t3_wrap_head", td, {2'b01, 32'h7, 32'hF0});
    chk("t3_wrap_count", tc, 1);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    chk("t3_drained", tc, 0);

    // T4 self-loop
    retire = 1'b1; pc = 32'h20; sp = 32'h200;
    ticks(3);
    chk("t4_status_3", st, 0);
    tick();
    retire = 1'b0;
    chk("t4_status_4", st, 1);
    chk("t4_halt", htq, 1);
    chk("t4_count", tc, 4);
    chk("t4_head", td, {2'b00, 32'h20, 32'h200});
    mem_we = 1'b1; mem_waddr = 32'hC; mem_wdata = 32'h1;
    tick();
    mem_we = 1'b0;
    chk("t4_frozen_count", tc, 4);
    chk("t4_frozen_drop", dc, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clr_status", st, 0);
    chk("t4_clr_halt", htq, 0);
    chk("t4_clr_count", tc, 4);
    chk("t4_clr_drop", dc, 3);
    trace_ready = 1'b1;
    ticks(4);
    trace_ready = 1'b0;

    // T5 timeout on the TIMEOUT=8 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    retire = 1'b1; pc = 32'h40;
    tick();
    retire = 1'b0;
    ticks(7);
    chk("t5_idle7", st_t, 0);
    tick();
    chk("t5_idle8_status", st_t, 2);
    chk("t5_idle8_halt", htq_t, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    retire = 1'b1; pc = 32'h44;
    tick();
    retire = 1'b0;
    ticks(7);
    retire = 1'b1; pc = 32'h48;
    tick();
    retire = 1'b0;
    chk("t5_saved_status", st_t, 0);
    chk("t5_saved_halt", htq_t, 0);
    ticks(7);
    chk("t5_again7", st_t, 0);
    tick();
    chk("t5_again8", st_t, 2);

    // T6 reset mid-run
    clear = 1'b1;
    tick();
    clear = 1'b0;
    reg_we = 1'b1; reg_waddr = 3'd1; reg_wdata = 32'h5;
    ticks(2);
    reg_we = 1'b0;
    ticks(6);
    chk("t6_pre_count", tc_t, 5);
    chk("t6_pre_status", st_t, 2);
    rst = 1'b1;
    tick();
    chk("t6_valid", tv_t, 0);
    chk("t6_count", tc_t, 0);
    chk("t6_drop", dc_t, 0);
    chk("t6_halt", htq_t, 0);
    chk("t6_status", st_t, 0);
    chk("t6_data", td_t, 0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
